seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8: number of multiplexed 7-segment digits, legal range 2..16.
REQ-002 SHALL have parameter SCAN_DIV, default 100000: clock cycles per digit slot, legal range 2 or more.
REQ-003 SHALL have parameter BLINK_DIV, default 64: full scan frames per blink half-period.
REQ-004 SHALL have localparam DATA_W = 4*NUM_DIGITS and PTR_W = clog2(NUM_DIGITS).
REQ-005 clock  in  1  sole clock; all state SHALL change on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 wr_en  in  1  display-data write strobe (the LEDCtrl-style IO write).
REQ-008 wr_data  in  DATA_W  hex nibbles; nibble i drives digit i.
REQ-009 mask_we  in  1  digit-enable mask write strobe.
REQ-010 mask_in  in  NUM_DIGITS  digit enable; 1 = digit lit.
REQ-011 dp_in  in  NUM_DIGITS  decimal point per digit, sampled on wr_en.
REQ-012 lz_en  in  1  leading-zero suppression enable, level-sensitive.
REQ-013 blink_mask  in  NUM_DIGITS  per-digit blink select, sampled on wr_en.
REQ-014 ena  out  NUM_DIGITS  one-hot digit anode enable, active-high, registered.
REQ-015 seg  out  8  {dp,g,f,e,d,c,b,a}, active-high, registered.
REQ-016 cur_digit  out  PTR_W  index of the digit currently driven.

Function
REQ-017 Prescaler SHALL count 0..SCAN_DIV-1 and assert internal tick for one cycle at SCAN_DIV-1, then wrap to 0.
REQ-018 On tick, cur_digit SHALL increment and wrap NUM_DIGITS-1 -> 0; the wrap SHALL also assert frame_tick.
REQ-019 On wr_en, data_r<=wr_data, dp_r<=dp_in and blink_r<=blink_mask in the same edge.
REQ-020 On mask_we, mask_r<=mask_in; mask_we and wr_en together SHALL both take effect.
REQ-021 ena/seg SHALL be registered from cur_digit, data_r, dp_r, mask_r, blink state: 1-cycle latency from any state change to the pins.
REQ-022 Digit i SHALL be blanked (ena all-zero, seg=8'h00) if mask_r[i]=0.
REQ-023 Digit i SHALL also be blanked if lz_en=1, i>0 and nibbles i..NUM_DIGITS-1 of data_r are all zero; digit 0 is never zero-suppressed.
REQ-024 Otherwise ena SHALL equal 1<<cur_digit and seg SHALL equal {dp_r[i], hex7(data_r nibble i)}, covering 0-F.
REQ-025 wr_en coincident with tick SHALL apply the new data to the newly selected digit on the following cycle; no stale frame is required.
REQ-026 ena SHALL never have more than one bit set in any cycle.

Reset
REQ-027 On reset_n=0, prescaler, cur_digit, data_r, dp_r, blink_r and blink counter SHALL clear to 0, and mask_r SHALL set to all-ones.
REQ-028 While reset_n=0, ena SHALL be all-zero and seg SHALL be 8'h00; reset mid-slot SHALL abort the slot immediately.
REQ-029 After release, digit 0 SHALL be driven starting the first rising edge after reset is removed.

Configuration
REQ-030 With SEG_BLINK_EN defined, a frame counter SHALL toggle blink_phase every BLINK_DIV frame_ticks, and digits with blink_r[i]=1 SHALL be blanked while blink_phase=1.
REQ-031 Without SEG_BLINK_EN, the blink counter SHALL be absent, blink_mask SHALL be ignored and blink_phase SHALL be fixed at 0.

Structure
REQ-032 A shared package seg_pkg SHALL hold the 16-entry hex-to-segment constant table, the SEG_BLANK constant and the default parameter values.
REQ-033 Combinational sub-module seg_hex7 (nibble in, 7 bits out) SHALL be instantiated once, on the muxed nibble.

Verification (NUM_DIGITS=8, SCAN_DIV=4, BLINK_DIV=2)
REQ-034 Reset release, no writes: ena SHALL be 8'h01 and seg=8'h3F; cur_digit SHALL step every 4 cycles, with ena reaching 8'h80 and then wrapping to 8'h01.
REQ-035 wr_data=32'h0000_00A5, lz_en=1: digit0 seg=8'h6D, digit1 seg=8'h77, digits 2-7 ena=0.
REQ-036 mask_we with mask_in=8'hF0, then wr_data=32'h1234_5678: digits 0-3 SHALL be dark, and digit4 SHALL show seg=8'h66 ("4").
REQ-037 wr_en pulsed in the same cycle as tick: the next digit SHALL show the new nibble one cycle later.
REQ-038 SEG_BLINK_EN, blink_mask=8'h01: digit0 SHALL be lit for 2 frames and dark for 2 frames, with other digits steady.
REQ-039 reset_n asserted mid-slot at cur_digit=5: ena SHALL be 0 in that cycle asynchronously, and SHALL restart at 8'h01 after release.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// the hex-to-segment table, the blank pattern and default parameter values.
package seg_pkg;

   // Default configuration values
   localparam int DEF_NUM_DIGITS = 8;
   localparam int DEF_SCAN_DIV   = 100000;
   localparam int DEF_BLINK_DIV  = 64;

   // Segment pattern driven while a digit is dark, {dp,g,f,e,d,c,b,a}
   localparam logic [7:0] SEG_BLANK = 8'h00;

   // Hex glyphs {g,f,e,d,c,b,a}, entry 0 in the low slice
   localparam logic [15:0][6:0] HEX7_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
      7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
      7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
      7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
   };

endpackage

// File: rtl/seg_hex7.sv
// Combinational hex nibble to 7-segment glyph decoder (active-high segments).
module seg_hex7
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] segs
);

   assign segs = HEX7_TABLE[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment display scan controller.
// Steps a one-hot anode enable across NUM_DIGITS digits, one digit per
// SCAN_DIV clocks, and drives the decoded glyph of the selected digit.
// Optional feature: define SEG_BLINK_EN to enable per-digit blinking with a
// half-period of BLINK_DIV full scan frames.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter  int NUM_DIGITS = DEF_NUM_DIGITS,
   parameter  int SCAN_DIV   = DEF_SCAN_DIV,
   parameter  int BLINK_DIV  = DEF_BLINK_DIV,
   localparam int DATA_W     = 4*NUM_DIGITS,
   localparam int PTR_W      = $clog2(NUM_DIGITS)
)(
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  wr_en,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  mask_we,
   input  logic [NUM_DIGITS-1:0] mask_in,
   input  logic [NUM_DIGITS-1:0] dp_in,
   input  logic                  lz_en,
   input  logic [NUM_DIGITS-1:0] blink_mask,
   output logic [NUM_DIGITS-1:0] ena,
   output logic [7:0]            seg,
   output logic [PTR_W-1:0]      cur_digit
);

   localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [PRE_W-1:0]      presc;
   logic                  tick;
   logic                  frame_tick;
   logic [DATA_W-1:0]     data_r;
   logic [NUM_DIGITS-1:0] dp_r;
   logic [NUM_DIGITS-1:0] mask_r;
   logic                  blink_phase;
   logic                  blink_blank;
   logic [NUM_DIGITS-1:0] lz_blank;
   logic [3:0]            cur_nib;
   logic [6:0]            cur_hex;
   logic                  blank_p0;
   logic [NUM_DIGITS-1:0] ena_p0;
   logic [7:0]            seg_p0;

   assign tick       = (presc == PRE_W'(SCAN_DIV-1));
   assign frame_tick = tick && (cur_digit == PTR_W'(NUM_DIGITS-1));

   // Slot prescaler: counts 0..SCAN_DIV-1, tick marks the last cycle of a slot
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)  presc <= '0;
      else if (tick) presc <= '0;
      else           presc <= presc + 1'b1;
   end

   // Digit pointer: advances once per slot and wraps at the last digit
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)        cur_digit <= '0;
      else if (frame_tick) cur_digit <= '0;
      else if (tick)       cur_digit <= cur_digit + 1'b1;
   end

   // Display data, decimal points and digit mask written from the host side
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_r <= '0;
         dp_r   <= '0;
         mask_r <= '1;
      end else begin
         if (wr_en) begin
            data_r <= wr_data;
            dp_r   <= dp_in;
         end
         if (mask_we) mask_r <= mask_in;
      end
   end

`ifdef SEG_BLINK_EN
   localparam int BCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [BCNT_W-1:0]     blink_cnt;
   logic [NUM_DIGITS-1:0] blink_r;

   // Blink timebase: phase flips after every BLINK_DIV completed frames
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_tick) begin
         if (blink_cnt == BCNT_W'(BLINK_DIV-1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   // Per-digit blink select, captured together with the display data
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)   blink_r <= '0;
      else if (wr_en) blink_r <= blink_mask;
   end

   assign blink_blank = blink_phase & blink_r[cur_digit];
`else
   logic unused_blink;

   assign blink_phase  = 1'b0;
   assign blink_blank  = blink_phase;
   assign unused_blink = ^blink_mask;
`endif

   // Digit i is a leading zero when it and every higher nibble are zero
   always_comb begin
      lz_blank = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         lz_blank[i] = ((data_r >> (4*i)) == '0);
   end

   assign cur_nib = data_r[4*cur_digit +: 4];

   seg_hex7 u_hex7 (
      .nibble (cur_nib),
      .segs   (cur_hex)
   );

   // Stage 0: decide lit/dark for the selected digit and form the pin values
   always_comb begin
      blank_p0 = !mask_r[cur_digit]
               || (lz_en && (cur_digit != '0) && lz_blank[cur_digit])
               || blink_blank;
      ena_p0   = '0;
      seg_p0   = SEG_BLANK;
      if (!blank_p0) begin
         ena_p0[cur_digit] = 1'b1;
         seg_p0            = {dp_r[cur_digit], cur_hex};
      end
   end

   // Stage 1: registered pins, forced dark while in reset
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ena <= '0;
         seg <= SEG_BLANK;
      end else begin
         ena <= ena_p0;
         seg <= seg_p0;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (NUM_DIGITS=8, SCAN_DIV=4, BLINK_DIV=2).
// A cycle-count based reference model predicts ena/seg/cur_digit; directed
// scenarios pin literal values, then randomized traffic runs against the model.
module tb_seg_scan_ctrl;

   localparam int ND = 8;
   localparam int SD = 4;
   localparam int BD = 2;
`ifdef SEG_BLINK_EN
   localparam bit BLINK_ON = 1'b1;
`else
   localparam bit BLINK_ON = 1'b0;
`endif

   localparam logic [6:0] HEX_TAB [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic          clock;
   logic          reset_n;
   logic          wr_en;
   logic [31:0]   wr_data;
   logic          mask_we;
   logic [7:0]    mask_in;
   logic [7:0]    dp_in;
   logic          lz_en;
   logic [7:0]    blink_mask;
   logic [7:0]    ena;
   logic [7:0]    seg;
   logic [2:0]    cur_digit;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_on = 1'b0;

   seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .mask_we    (mask_we),
      .mask_in    (mask_in),
      .dp_in      (dp_in),
      .lz_en      (lz_en),
      .blink_mask (blink_mask),
      .ena        (ena),
      .seg        (seg),
      .cur_digit  (cur_digit)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   int unsigned m_n     = 0;
   logic [31:0] m_data  = '0;
   logic [7:0]  m_dp    = '0;
   logic [7:0]  m_mask  = 8'hFF;
   logic [7:0]  m_blink = '0;
   logic [7:0]  exp_ena = '0;
   logic [7:0]  exp_seg = '0;
   logic [2:0]  exp_cur = '0;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_n = 0; m_data = '0; m_dp = '0; m_mask = 8'hFF; m_blink = '0;
         exp_ena = '0; exp_seg = '0; exp_cur = '0;
      end else begin
         int d, frame, msd;
         bit lit, phase;
         d     = (m_n / SD) % ND;
         frame = m_n / (SD * ND);
         phase = BLINK_ON && (((frame / BD) % 2) == 1);
         msd   = 0;
         for (int k = 0; k < ND; k++)
            if (m_data[4*k +: 4] != 4'h0) msd = k;
         lit = m_mask[d];
         if (lz_en && d > msd) lit = 1'b0;
         if (phase && m_blink[d]) lit = 1'b0;
         exp_ena = lit ? 8'(1 << d) : 8'h00;
         exp_seg = lit ? {m_dp[d], HEX_TAB[m_data[4*d +: 4]]} : 8'h00;
         if (wr_en) begin
            m_data  = wr_data;
            m_dp    = dp_in;
            m_blink = blink_mask;
         end
         if (mask_we) m_mask = mask_in;
         m_n++;
         exp_cur = 3'((m_n / SD) % ND);
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clock) begin
      if (chk_on) begin
         check("ena", ena, exp_ena);
         check("seg", seg, exp_seg);
         check("cur_digit", cur_digit, exp_cur);
         check("ena_onehot", ($countones(ena) <= 1), 1);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int k);
      repeat (k) @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      wr_en = 1'b0; wr_data = '0; mask_we = 1'b0; mask_in = '0;
      dp_in = '0; blink_mask = '0; lz_en = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      idle_inputs();
      step(2);
   endtask

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      step(2);
      chk_on = 1'b1;
      check("rst_ena", ena, 8'h00);
      check("rst_seg", seg, 8'h00);

      // Free-running scan after release, no writes
      do_reset();
      reset_n = 1'b1;
      step(1);
      check("scan_first_ena", ena, 8'h01);
      check("scan_first_seg", seg, 8'h3F);
      step(28);
      check("scan_last_ena", ena, 8'h80);
      step(4);
      check("scan_wrap_ena", ena, 8'h01);

      // Leading-zero suppression on 0xA5
      do_reset();
      wr_en = 1'b1; wr_data = 32'h0000_00A5; lz_en = 1'b1;
      reset_n = 1'b1;
      step(1);
      check("lz_pre_seg", seg, 8'h3F);
      wr_en = 1'b0;
      step(1);
      check("lz_d0_seg", seg, 8'h6D);
      step(3);
      check("lz_d1_ena", ena, 8'h02);
      check("lz_d1_seg", seg, 8'h77);
      step(4);
      check("lz_d2_ena", ena, 8'h00);
      check("lz_d2_seg", seg, 8'h00);

      // Mask 0xF0 written together with data 0x12345678
      do_reset();
      mask_we = 1'b1; mask_in = 8'hF0; wr_en = 1'b1; wr_data = 32'h1234_5678;
      reset_n = 1'b1;
      step(1);
      mask_we = 1'b0; wr_en = 1'b0;
      step(1);
      check("mask_d0_ena", ena, 8'h00);
      step(11);
      check("mask_d3_ena", ena, 8'h00);
      step(4);
      check("mask_d4_ena", ena, 8'h10);
      check("mask_d4_seg", seg, 8'h66);

      // Write coincident with the slot tick
      do_reset();
      reset_n = 1'b1;
      step(3);
      wr_en = 1'b1; wr_data = 32'h0000_00E0;
      step(1);
      check("tickwr_old_seg", seg, 8'h3F);
      wr_en = 1'b0;
      step(1);
      check("tickwr_new_ena", ena, 8'h02);
      check("tickwr_new_seg", seg, 8'h79);

      // Blink select on digit 0
      do_reset();
      wr_en = 1'b1; blink_mask = 8'h01;
      reset_n = 1'b1;
      step(1);
      check("blink_f0_ena", ena, 8'h01);
      wr_en = 1'b0; blink_mask = 8'h00;
      step(64);
`ifdef SEG_BLINK_EN
      check("blink_f2_ena", ena, 8'h00);
`else
      check("blink_f2_ena", ena, 8'h01);
`endif
      step(4);
      check("blink_f2_d1_ena", ena, 8'h02);
      step(60);
      check("blink_f4_ena", ena, 8'h01);

      // Asynchronous reset in the middle of digit 5's slot
      begin
         int waited;
         waited = 0;
         while (cur_digit != 3'd5 && waited < 100) begin
            step(1);
            waited++;
         end
         check("wait_d5", cur_digit, 3'd5);
         step(1);
         check("mid_d5_ena", ena, 8'h20);
         reset_n = 1'b0;
         #1;
         check("async_ena", ena, 8'h00);
         check("async_seg", seg, 8'h00);
         check("async_cur", cur_digit, 3'd0);
         step(2);
         reset_n = 1'b1;
         step(1);
         check("restart_ena", ena, 8'h01);
      end

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         wr_en      = ($urandom_range(0, 7) == 0);
         wr_data    = $urandom >> (4 * $urandom_range(0, 8));
         dp_in      = 8'($urandom);
         blink_mask = 8'($urandom);
         mask_we    = ($urandom_range(0, 15) == 0);
         mask_in    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
         if ($urandom_range(0, 63) == 0) lz_en = ~lz_en;
         if ($urandom_range(0, 999) == 0) begin
            reset_n = 1'b0;
            step(1);
            reset_n = 1'b1;
         end
         step(1);
      end

      idle_inputs();
      step(2);
      chk_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
